// File: rtl/dpi_echo_responder.sv
// Responder side of the increment request/response exchange: fixed-latency compute
// pipeline feeding an in-order response FIFO, with credit-based request flow control.
module dpi_echo_responder #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    output logic [15:0]      req_count,
    output logic [7:0]       err_count
);

    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam int unsigned NSTG = (LATENCY > 1) ? LATENCY - 1 : 1;

    typedef struct packed {
        logic             err;
        logic [WIDTH-1:0] data;
    } resp_t;

    logic              accept;
    logic              pop;
    resp_t             calc_c;
    logic              wr_en;
    resp_t             wr_ent;

    logic [NSTG-1:0]   pv_q, pv_d;
    resp_t             pd_q [NSTG];
    resp_t             pd_d [NSTG];
    resp_t             mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     occ_q, occ_d;
    logic [CW-1:0]     used_q, used_d;
    logic              ready_q, ready_d;
    logic              rvalid_q, rvalid_d;
    logic [15:0]       req_cnt_q, req_cnt_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    assign accept = req_valid & ready_q;
    assign pop    = rvalid_q & resp_ready;

    // Opcode decode and result arithmetic (modulo 2^WIDTH)
    always_comb begin
        calc_c = '0;
        case (req_op)
            2'd0:    calc_c.data = req_data + WIDTH'(1);
            2'd1:    calc_c.data = req_data + WIDTH'(2);
            2'd2:    calc_c.data = req_data;
            default: calc_c.err  = 1'b1;
        endcase
    end

    // Stage 0 captures on accept; the final stage feeds the FIFO write port
    always_comb begin
        pv_d    = '0;
        pv_d[0] = accept;
        for (int unsigned i = 0; i < NSTG; i++) begin
            pd_d[i] = pd_q[i];
        end
        if (accept) begin
            pd_d[0] = calc_c;
        end
        for (int unsigned i = 1; i < NSTG; i++) begin
            pv_d[i] = pv_q[i-1];
            pd_d[i] = pd_q[i-1];
        end
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            assign wr_en  = accept;
            assign wr_ent = calc_c;
        end else begin : g_latn
            assign wr_en  = pv_q[NSTG-1];
            assign wr_ent = pd_q[NSTG-1];
        end
    endgenerate

    // FIFO pointers, occupancy, credits and statistics counters
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        used_d    = used_q;
        req_cnt_d = req_cnt_q;
        err_cnt_d = err_cnt_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({wr_en, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase

        case ({accept, pop})
            2'b10:   used_d = used_q + CW'(1);
            2'b01:   used_d = used_q - CW'(1);
            default: used_d = used_q;
        endcase

        if (accept) begin
            req_cnt_d = req_cnt_q + 16'd1;
            if (req_op == 2'd3 && err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end

        // Ready is a registered view of the post-update credit count, so a pop
        // only reopens the request port from the following cycle.
        ready_d  = (used_d < CW'(DEPTH));
        rvalid_d = (occ_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            used_q    <= '0;
            ready_q   <= 1'b1;
            rvalid_q  <= 1'b0;
            req_cnt_q <= '0;
            err_cnt_q <= '0;
            for (int unsigned i = 0; i < NSTG; i++) begin
                pd_q[i] <= '0;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pv_q      <= pv_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            used_q    <= used_d;
            ready_q   <= ready_d;
            rvalid_q  <= rvalid_d;
            req_cnt_q <= req_cnt_d;
            err_cnt_q <= err_cnt_d;
            for (int unsigned i = 0; i < NSTG; i++) begin
                pd_q[i] <= pd_d[i];
            end
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wr_ent;
            end
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = rvalid_q;
    assign resp_data  = mem_q[rd_ptr_q].data;
    assign resp_err   = mem_q[rd_ptr_q].err;
    assign req_count  = req_cnt_q;
    assign err_count  = err_cnt_q;

endmodule

// File: doc/dpi_echo_responder.md
Name: dpi_echo_responder

Overview:
- Responder end of the increment request/response exchange driven by the secret_sub-style initiator.
- The initiator sends an operand plus opcode. This block computes the result through a fixed-latency pipeline and buffers responses in a FIFO.
- Responses are returned in request order over a valid/ready handshake.
- Used as the synthesizable stand-in for the DPI task/function side in protect-ids regression tests.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).
- DEPTH, 4, response FIFO entries; power of two, ≥2. Also the total outstanding-request limit.
- LATENCY, 2, compute pipeline stages from request acceptance to FIFO write (≥1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_op  input  2  0=task (+1), 1=func (+2), 2=echo, 3=illegal.
- req_data  input  WIDTH  operand.
- resp_valid  output  1  FIFO head valid.
- resp_ready  input  1  initiator takes the response.
- resp_data  output  WIDTH  result.
- resp_err  output  1  response came from an illegal opcode.
- req_count  output  16  accepted requests, wraps at 2^16.
- err_count  output  8  illegal-op requests, saturates at 255.

Behaviour:
- Accept = req_valid & req_ready at a rising edge. Pop = resp_valid & resp_ready.
- Result arithmetic, modulo 2^WIDTH:
  - op0: data+1. Wraps, so all-ones → 0.
  - op1: data+2. All-ones → 1.
  - op2: data unchanged, err=0.
  - op3: data=0, err=1.
- Pipeline: LATENCY stages of {valid, result, err}.
  - A request accepted at edge N is written into the FIFO at edge N+LATENCY−1.
  - It is visible as resp_valid after that edge if the FIFO was empty.
  - With LATENCY=2: request at edge N gives resp_valid=1 in the cycle after edge N+1.
  - The pipeline never stalls. Credit accounting guarantees FIFO space.
- Credits: used = in-flight pipeline entries + FIFO occupancy, held in a registered counter 0..DEPTH.
  - req_ready = (used < DEPTH), decoded from registers only. No combinational path from resp_ready or req_valid.
  - used increments on accept and decrements on pop. Both in the same cycle leaves it unchanged.
  - A pop frees its credit for acceptance from the next cycle, not the same one.
- FIFO: circular buffer with wrapping read/write pointers (log2(DEPTH) bits) plus occupancy.
  - resp_data and resp_err come directly from the head entry.
  - resp_valid = occupancy ≠ 0.
  - Write and pop in the same cycle when occupancy is 1 or full are both legal. Occupancy stays unchanged.
- Ordering: responses leave in strict acceptance order. No reordering and no drops.
- Counters:
  - req_count increments on every accept.
  - err_count increments on accept with op3 and holds at 255.
- Backpressure: resp_ready low indefinitely must preserve the FIFO contents. Once DEPTH requests are outstanding, req_ready=0.
- Reset (async assert, any time, including mid-pipeline or with FIFO full):
  - Pipeline valids, pointers, occupancy, credits and counters all go to 0.
  - Outputs: req_ready=1 (the same cycle, combinationally from reset state), resp_valid=0, resp_data=0, resp_err=0, req_count=0, err_count=0.
  - In-flight and buffered responses are discarded.
- Reset deassertion: the block is ready to accept on the first rising edge after release.
- X-safety: req_op and req_data are ignored when req_valid=0. Counters never increment without an accept.

Test Plan:
1. Reset, then send op0/data=5 with resp_ready=1 → resp_valid high LATENCY cycles after accept, resp_data=6, resp_err=0, req_count=1.
2. Back-to-back op1 with data=0xFFFFFFFF, then op0 with data=0xFFFFFFFF → resp_data=0x00000001 then 0x00000000, in order.
3. Hold resp_ready=0 and stream 10 requests (op2, data=0..9) → req_ready drops after 4 accepts. FIFO holds 0,1,2,3. Releasing resp_ready drains 0..9 in order, with req_ready regaining one cycle after each pop.
4. Send op3 300 times → each response has resp_err=1 and data=0. err_count saturates at 255. req_count=300.
5. Full FIFO with resp_ready=1 and req_valid=1 every cycle → sustained one accept/one pop per cycle after the first credit lag. No loss, no duplication, data matches a scoreboard.
6. Assert rst with the FIFO holding 3 entries and 1 in flight → resp_valid=0 and req_ready=1 immediately. After release, a new op0/data=7 returns 8 as the first response, with nothing stale.
